mem_controller: RTL and testbench

- Dual-bank vector buffer for the dot-product datapath.
- Captures a burst of paired operands, data_a into bank A and data_b into bank B, in lockstep at a shared auto-incrementing write pointer.
- Exposes two independent synchronous read ports so the downstream MAC can fetch element pairs.
- Signals burst progress with busy and completion with done.

---
 rtl/mem_controller.sv | 109 ++++++++++
 tb/tb_mem_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mem_controller
//  Purpose  : Dual-bank operand buffer. Lockstep burst writes into banks A/B
//             and two independent registered read ports for the MAC.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_controller #(
    parameter int DATA_WIDTH  = 8,
    parameter int VETOR_WIDTH = 4,
    localparam int DEPTH      = VETOR_WIDTH * DATA_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  busy,
    output logic                  done,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   dout_a_q, dout_a_d;
    logic [DATA_WIDTH-1:0]   dout_b_q, dout_b_d;
    logic [DATA_WIDTH-1:0]   bank_a_q [DEPTH];
    logic [DATA_WIDTH-1:0]   bank_b_q [DEPTH];
    logic                    w_write;

    // A start with in_valid already high writes word 0 on the same edge.
    assign w_write = in_valid && ((state_q == S_WRITE) || start);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;

        if (w_write && (wr_ptr_q == C_LAST)) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end else if (w_write) begin
            state_d  = S_WRITE;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            busy_d   = 1'b1;
        end else if ((state_q == S_IDLE) && start) begin
            state_d  = S_WRITE;
            busy_d   = 1'b1;
        end

        // Reads see the pre-edge bank contents, giving read-first collisions.
        if (rd_en_a) dout_a_d = bank_a_q[rd_addr_a];
        if (rd_en_b) dout_b_d = bank_b_q[rd_addr_b];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_a_q <= '0;
            dout_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_a_q[i] <= '0;
                bank_b_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            if (w_write) begin
                bank_a_q[wr_ptr_q] <= data_a;
                bank_b_q[wr_ptr_q] <= data_b;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_controller
//  Purpose  : Directed self-checking bench for mem_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          busy;
    logic          done;
    logic          rd_en_a = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [DW-1:0] dout_a;
    logic          rd_en_b = 1'b0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] dout_b;

    int errors = 0;
    int checks = 0;

    mem_controller #(.DATA_WIDTH(8), .VETOR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .dout_a(dout_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        #3;
        rst_n = 1'b0;
        tick();
    endtask

    task automatic read_pair(input logic [AW-1:0] addr);
        rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = addr; rd_addr_b = addr;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        checks++;
        if ({busy, done, dout_a, dout_b} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b a=%0d b=%0d, want all 0", busy, done, dout_a, dout_b);
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_partial_burst();
        logic [DW-1:0] ea [3] = '{8'd10, 8'd20, 8'd30};
        logic [DW-1:0] eb [3] = '{8'd200, 8'd150, 8'd100};
        apply_reset();
        start = 1'b1; in_valid = 1'b1; data_a = 8'd10; data_b = 8'd200;
        tick();
        start = 1'b0; in_valid = 1'b0;
        tick();
        in_valid = 1'b1; data_a = 8'd20; data_b = 8'd150;
        tick();
        data_a = 8'd30; data_b = 8'd100;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_pair(AW'(i));
            checks++;
            if (dout_a !== ea[i] || dout_b !== eb[i]) begin
                errors++;
                $display("FAIL partial_read[%0d]: a=%0d b=%0d, want %0d/%0d", i, dout_a, dout_b, ea[i], eb[i]);
            end
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL partial_status: busy=%0b done=%0b, want 1/0", busy, done);
        end
    endtask

    task automatic test_full_burst();
        logic [DW-1:0] v;
        int pulses = 0;
        apply_reset();
        start = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            in_valid = 1'b1; data_a = v; data_b = ~v;
            tick();
            start = 1'b0;
            if (done === 1'b1) pulses++;
            checks++;
            if (done !== (i == DEPTH - 1) || busy !== (i != DEPTH - 1)) begin
                errors++;
                $display("FAIL full_status[%0d]: done=%0b busy=%0b, want %0b/%0b", i, done, busy, i == DEPTH - 1, i != DEPTH - 1);
            end
        end
        in_valid = 1'b0;
        tick();
        if (done === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: pulses=%0d done=%0b busy=%0b, want 1/0/0", pulses, done, busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            read_pair(AW'(i));
            checks++;
            if (dout_a !== v || dout_b !== ~v) begin
                errors++;
                $display("FAIL full_read[%0d]: a=%0d b=%0d, want %0d/%0d", i, dout_a, dout_b, v, ~v);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        apply_reset();
        in_valid = 1'b1; data_a = 8'd55; data_b = 8'd66;
        tick();
        tick();
        in_valid = 1'b0;
        read_pair(AW'(0));
        checks++;
        if (dout_a !== 8'd0 || dout_b !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_write: a=%0d b=%0d busy=%0b, want 0/0/0", dout_a, dout_b, busy);
        end
        start = 1'b1; in_valid = 1'b1; data_a = 8'd1; data_b = 8'd2;
        tick();
        start = 1'b0; data_a = 8'd3; data_b = 8'd4;
        tick();
        start = 1'b1; data_a = 8'd5; data_b = 8'd6;
        tick();
        start = 1'b0; in_valid = 1'b0;
        read_pair(AW'(2));
        checks++;
        if (dout_a !== 8'd5 || dout_b !== 8'd6) begin
            errors++;
            $display("FAIL restart_ptr_addr2: a=%0d b=%0d, want 5/6", dout_a, dout_b);
        end
        read_pair(AW'(1));
        checks++;
        if (dout_a !== 8'd3 || dout_b !== 8'd4) begin
            errors++;
            $display("FAIL restart_ptr_addr1: a=%0d b=%0d, want 3/4", dout_a, dout_b);
        end
    endtask

    task automatic test_hold_and_collision();
        // Continues the burst above: next write lands at address 3.
        rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = AW'(2); rd_addr_b = AW'(2);
        tick();
        checks++;
        if (dout_a !== 8'd3 || dout_b !== 8'd4) begin
            errors++;
            $display("FAIL read_hold: a=%0d b=%0d, want 3/4", dout_a, dout_b);
        end
        in_valid = 1'b1; data_a = 8'd77; data_b = 8'd88;
        read_pair(AW'(3));
        in_valid = 1'b0;
        checks++;
        if (dout_a !== 8'd0 || dout_b !== 8'd0) begin
            errors++;
            $display("FAIL collision_old: a=%0d b=%0d, want 0/0", dout_a, dout_b);
        end
        read_pair(AW'(3));
        checks++;
        if (dout_a !== 8'd77 || dout_b !== 8'd88) begin
            errors++;
            $display("FAIL collision_new: a=%0d b=%0d, want 77/88", dout_a, dout_b);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; data_a = DW'(i + 1); data_b = DW'(i + 101);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        read_pair(AW'(0));
        checks++;
        if (dout_a !== 8'd1 || dout_b !== 8'd101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: a=%0d b=%0d busy=%0b, want 1/101/1", dout_a, dout_b, busy);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout_a !== 8'd0 || dout_b !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%0b done=%0b a=%0d b=%0d, want all 0", busy, done, dout_a, dout_b);
        end
        #1;
        rst_n = 1'b0;
        start = 1'b1; in_valid = 1'b1; data_a = 8'd9; data_b = 8'd19;
        tick();
        start = 1'b0; in_valid = 1'b0;
        read_pair(AW'(0));
        checks++;
        if (dout_a !== 8'd9 || dout_b !== 8'd19) begin
            errors++;
            $display("FAIL new_burst_addr0: a=%0d b=%0d, want 9/19", dout_a, dout_b);
        end
        read_pair(AW'(4));
        checks++;
        if (dout_a !== 8'd0 || dout_b !== 8'd0) begin
            errors++;
            $display("FAIL cleared_addr4: a=%0d b=%0d, want 0/0", dout_a, dout_b);
        end
    endtask

    initial begin
        test_reset();
        test_partial_burst();
        test_full_burst();
        test_ignored_inputs();
        test_hold_and_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
